// File: rtl/ss_rvc_dmem_arb.sv
// Data-memory arbiter for ss_rvc: shares the single-port D_MEM between the core LSU (C)
// and the external debug/loader port (E), decodes the D_MEM window and returns in-order responses.

package ss_rvc_pkg;
  localparam int XLEN       = 32;
  localparam int SIZE_I_MEM = 1024;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } t_req_op;
endpackage

module ss_rvc_dmem_arb
  import ss_rvc_pkg::*;
#(
  parameter int MSB_D_MEM    = 9,
  parameter int D_MEM_OFFSET = SIZE_I_MEM,
  parameter int RD_LAT       = 1
) (
  input  logic                   QClk,
  input  logic                   RstQnnnL,
  // core load/store unit
  input  logic                   c_req,
  input  t_req_op                c_op,
  input  logic [XLEN-1:0]        c_addr,
  input  logic [XLEN-1:0]        c_wdata,
  output logic                   c_ack,
  output logic                   c_rsp_valid,
  output logic                   c_rsp_err,
  output logic [XLEN-1:0]        c_rsp_rdata,
  // external debug/loader port
  input  logic                   e_req,
  input  t_req_op                e_op,
  input  logic [XLEN-1:0]        e_addr,
  input  logic [XLEN-1:0]        e_wdata,
  output logic                   e_ack,
  output logic                   e_rsp_valid,
  output logic                   e_rsp_err,
  output logic [XLEN-1:0]        e_rsp_rdata,
  input  logic                   e_lock,
  // D_MEM macro
  output logic                   mem_en,
  output logic                   mem_wr,
  output logic [MSB_D_MEM-2:0]   mem_addr,
  output logic [XLEN-1:0]        mem_wdata,
  input  logic [XLEN-1:0]        mem_rdata
);

  localparam int              SIZE_D_MEM = 2 ** (MSB_D_MEM + 1);
  localparam logic [XLEN-1:0] WIN_LO     = XLEN'(D_MEM_OFFSET);
  localparam logic [XLEN-1:0] WIN_HI     = XLEN'(D_MEM_OFFSET + SIZE_D_MEM);

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_E = 1'b1
  } t_owner;

  typedef struct packed {
    logic   valid;
    t_owner owner;
    logic   err;
    logic   is_rd;
  } t_rsp_slot;

  t_owner          last_grant;
  logic            grant_c;
  logic            grant_e;
  logic            any_grant;
  t_req_op         win_op;
  logic [XLEN-1:0] win_addr;
  logic [XLEN-1:0] win_wdata;
  logic [XLEN-1:0] win_off;
  logic            addr_ok;
  t_rsp_slot       pipe [RD_LAT];
  t_rsp_slot       head;
  logic [XLEN-1:0] rsp_rdata;
  logic            unused_off_bits;

  // Arbitration: lock gives E absolute priority, otherwise round-robin on contention.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    grant_c = 1'b0;
    grant_e = 1'b0;
    if (RstQnnnL) begin
      if (c_req && e_req) begin
        if (e_lock || last_grant == OWN_C) grant_e = 1'b1;
        else                               grant_c = 1'b1;
      end else begin
        grant_c = c_req;
        grant_e = e_req;
      end
    end
  end

  assign any_grant = grant_c | grant_e;
  assign c_ack     = grant_c;
  assign e_ack     = grant_e;

  assign win_op    = grant_e ? e_op    : c_op;
  assign win_addr  = grant_e ? e_addr  : c_addr;
  assign win_wdata = grant_e ? e_wdata : c_wdata;

  // Window decode; the offset's upper bits are only meaningful inside the window.
  assign win_off = win_addr - WIN_LO;
  assign addr_ok = (win_addr >= WIN_LO) && (win_addr < WIN_HI) && (win_addr[1:0] == 2'b00);
  assign unused_off_bits = ^{win_off[XLEN-1:MSB_D_MEM+1], win_off[1:0]};

  assign mem_en    = any_grant && addr_ok;
  assign mem_wr    = mem_en && (win_op == REQ_WR);
  assign mem_addr  = mem_en ? win_off[MSB_D_MEM:2] : '0;
  assign mem_wdata = mem_en ? win_wdata : '0;

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      // NOTE: the response pipe is reset (unlike a RAM array) so in-flight responses die with reset.
      last_grant <= OWN_E;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments let each stage shift from its pre-edge value.
      if (any_grant) last_grant <= grant_e ? OWN_E : OWN_C;
      pipe[0] <= '{valid: any_grant,
                   owner: (grant_e ? OWN_E : OWN_C),
                   err:   any_grant && !addr_ok,
                   is_rd: (win_op == REQ_RD)};
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // The last stage lines up with mem_rdata; memory output is ignored unless a valid read is due.
  assign head      = pipe[RD_LAT-1];
  assign rsp_rdata = (head.valid && head.is_rd && !head.err) ? mem_rdata : '0;

  assign c_rsp_valid = head.valid && (head.owner == OWN_C);
  assign c_rsp_err   = c_rsp_valid && head.err;
  assign c_rsp_rdata = c_rsp_valid ? rsp_rdata : '0;

  assign e_rsp_valid = head.valid && (head.owner == OWN_E);
  assign e_rsp_err   = e_rsp_valid && head.err;
  assign e_rsp_rdata = e_rsp_valid ? rsp_rdata : '0;

endmodule

// File: tb/tb_ss_rvc_dmem_arb.sv
// Directed bench for ss_rvc_dmem_arb: a vector table on an RD_LAT=1 instance plus
// hand sequences for RD_LAT=2 back-to-back reads and reset in the middle of a read.

module tb_ss_rvc_dmem_arb;
  import ss_rvc_pkg::*;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;
  localparam logic [31:0] Z = 32'h0;
  localparam t_req_op RD = REQ_RD;
  localparam t_req_op WR = REQ_WR;

  logic QClk;
  logic RstQnnnL;

  // instance 1 (RD_LAT = 1)
  logic        c_req, e_req, e_lock;
  t_req_op     c_op, e_op;
  logic [31:0] c_addr, c_wdata, e_addr, e_wdata;
  logic        c_ack, c_rsp_valid, c_rsp_err;
  logic        e_ack, e_rsp_valid, e_rsp_err;
  logic [31:0] c_rsp_rdata, e_rsp_rdata;
  logic        mem_en, mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  // instance 2 (RD_LAT = 2), core side only
  logic        d2_c_req;
  t_req_op     d2_c_op;
  logic [31:0] d2_c_addr;
  logic        d2_c_ack, d2_c_rsp_valid, d2_c_rsp_err;
  logic [31:0] d2_c_rsp_rdata;
  logic        d2_e_ack, d2_e_rsp_valid, d2_e_rsp_err;
  logic [31:0] d2_e_rsp_rdata;
  logic        d2_mem_en, d2_mem_wr;
  logic [7:0]  d2_mem_addr;
  logic [31:0] d2_mem_wdata, d2_mem_rdata, d2_p0;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  ss_rvc_dmem_arb #(.RD_LAT(1)) dut1 (
    .QClk(QClk), .RstQnnnL(RstQnnnL),
    .c_req(c_req), .c_op(c_op), .c_addr(c_addr), .c_wdata(c_wdata), .c_ack(c_ack),
    .c_rsp_valid(c_rsp_valid), .c_rsp_err(c_rsp_err), .c_rsp_rdata(c_rsp_rdata),
    .e_req(e_req), .e_op(e_op), .e_addr(e_addr), .e_wdata(e_wdata), .e_ack(e_ack),
    .e_rsp_valid(e_rsp_valid), .e_rsp_err(e_rsp_err), .e_rsp_rdata(e_rsp_rdata),
    .e_lock(e_lock),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  ss_rvc_dmem_arb #(.RD_LAT(2)) dut2 (
    .QClk(QClk), .RstQnnnL(RstQnnnL),
    .c_req(d2_c_req), .c_op(d2_c_op), .c_addr(d2_c_addr), .c_wdata(32'h0), .c_ack(d2_c_ack),
    .c_rsp_valid(d2_c_rsp_valid), .c_rsp_err(d2_c_rsp_err), .c_rsp_rdata(d2_c_rsp_rdata),
    .e_req(1'b0), .e_op(REQ_RD), .e_addr(32'h0), .e_wdata(32'h0), .e_ack(d2_e_ack),
    .e_rsp_valid(d2_e_rsp_valid), .e_rsp_err(d2_e_rsp_err), .e_rsp_rdata(d2_e_rsp_rdata),
    .e_lock(1'b0),
    .mem_en(d2_mem_en), .mem_wr(d2_mem_wr), .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
    .mem_rdata(d2_mem_rdata)
  );

  initial QClk = 1'b0;
  always #5 QClk = ~QClk;

  // Memory model: word i holds 0x1000_0000+i, word 2 holds 0xDEADBEEF; idle output is junk.
  always @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 + 32'(i);
      mem[2]    <= 32'hDEAD_BEEF;
      mem_rdata <= 32'hBAD0_BAD0;
    end else begin
      if (mem_en && mem_wr) mem[mem_addr] <= mem_wdata;
      mem_rdata <= (mem_en && !mem_wr) ? mem[mem_addr] : 32'hBAD0_BAD0;
    end
  end

  always @(posedge QClk) begin
    d2_p0        <= (d2_mem_en && !d2_mem_wr) ? mem[d2_mem_addr] : 32'hBAD0_BAD0;
    d2_mem_rdata <= d2_p0;
  end

  typedef struct {
    logic        c_req;  t_req_op c_op; logic [31:0] c_addr; logic [31:0] c_wdata;
    logic        e_req;  t_req_op e_op; logic [31:0] e_addr; logic [31:0] e_wdata;
    logic        e_lock;
    logic        x_c_ack; logic x_e_ack; logic x_en; logic x_wr; logic [7:0] x_maddr;
    logic        x_cv; logic x_ce; logic [31:0] x_crd;
    logic        x_ev; logic x_ee; logic [31:0] x_erd;
  } vec_t;

  function automatic vec_t mk(
    input logic cr, input t_req_op co, input logic [31:0] ca, input logic [31:0] cw,
    input logic er, input t_req_op eo, input logic [31:0] ea, input logic [31:0] ew,
    input logic lk,
    input logic xca, input logic xea, input logic xen, input logic xwr, input logic [7:0] xma,
    input logic xcv, input logic xce, input logic [31:0] xcr,
    input logic xev, input logic xee, input logic [31:0] xer);
    vec_t v;
    v.c_req = cr; v.c_op = co; v.c_addr = ca; v.c_wdata = cw;
    v.e_req = er; v.e_op = eo; v.e_addr = ea; v.e_wdata = ew; v.e_lock = lk;
    v.x_c_ack = xca; v.x_e_ack = xea; v.x_en = xen; v.x_wr = xwr; v.x_maddr = xma;
    v.x_cv = xcv; v.x_ce = xce; v.x_crd = xcr;
    v.x_ev = xev; v.x_ee = xee; v.x_erd = xer;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    c_req = N; c_op = RD; c_addr = Z; c_wdata = Z;
    e_req = N; e_op = RD; e_addr = Z; e_wdata = Z; e_lock = N;
    d2_c_req = N; d2_c_op = RD; d2_c_addr = Z;
  endtask

  vec_t vecs [19];

  initial begin
    // Responses in row k come from the ack in row k-1.
    vecs[0]  = mk(N,RD,Z,Z,              N,RD,Z,Z,              N, N,N,N,N,8'd0,   N,N,Z,            N,N,Z);
    vecs[1]  = mk(Y,RD,32'h408,Z,        N,RD,Z,Z,              N, Y,N,Y,N,8'd2,   N,N,Z,            N,N,Z);
    vecs[2]  = mk(N,RD,Z,Z,              N,RD,Z,Z,              N, N,N,N,N,8'd0,   Y,N,32'hDEADBEEF, N,N,Z);
    vecs[3]  = mk(N,RD,Z,Z,              Y,WR,32'h3FC,32'h5,    N, N,Y,N,N,8'd0,   N,N,Z,            N,N,Z);
    vecs[4]  = mk(Y,RD,32'h400,Z,        Y,RD,32'h404,Z,        N, Y,N,Y,N,8'd0,   N,N,Z,            Y,Y,Z);
    vecs[5]  = mk(Y,RD,32'h400,Z,        Y,RD,32'h404,Z,        N, N,Y,Y,N,8'd1,   Y,N,32'h10000000, N,N,Z);
    vecs[6]  = mk(Y,RD,32'h400,Z,        Y,RD,32'h404,Z,        N, Y,N,Y,N,8'd0,   N,N,Z,            Y,N,32'h10000001);
    vecs[7]  = mk(Y,RD,32'h400,Z,        Y,RD,32'h404,Z,        N, N,Y,Y,N,8'd1,   Y,N,32'h10000000, N,N,Z);
    vecs[8]  = mk(Y,RD,32'h400,Z,        Y,RD,32'h404,Z,        Y, N,Y,Y,N,8'd1,   N,N,Z,            Y,N,32'h10000001);
    vecs[9]  = mk(Y,RD,32'h400,Z,        Y,RD,32'h404,Z,        Y, N,Y,Y,N,8'd1,   N,N,Z,            Y,N,32'h10000001);
    vecs[10] = mk(Y,RD,32'h400,Z,        Y,RD,32'h404,Z,        Y, N,Y,Y,N,8'd1,   N,N,Z,            Y,N,32'h10000001);
    vecs[11] = mk(Y,RD,32'h400,Z,        Y,RD,32'h404,Z,        N, Y,N,Y,N,8'd0,   N,N,Z,            Y,N,32'h10000001);
    vecs[12] = mk(Y,RD,32'h402,Z,        N,RD,Z,Z,              N, Y,N,N,N,8'd0,   Y,N,32'h10000000, N,N,Z);
    vecs[13] = mk(Y,RD,32'h7FC,Z,        N,RD,Z,Z,              N, Y,N,Y,N,8'd255, Y,Y,Z,            N,N,Z);
    vecs[14] = mk(Y,WR,32'h404,32'hCAFEF00D, N,RD,Z,Z,          N, Y,N,Y,Y,8'd1,   Y,N,32'h100000FF, N,N,Z);
    vecs[15] = mk(Y,RD,32'h404,Z,        N,RD,Z,Z,              N, Y,N,Y,N,8'd1,   Y,N,Z,            N,N,Z);
    vecs[16] = mk(Y,RD,32'h800,Z,        N,RD,Z,Z,              N, Y,N,N,N,8'd0,   Y,N,32'hCAFEF00D, N,N,Z);
    vecs[17] = mk(N,RD,Z,Z,              N,RD,Z,Z,              N, N,N,N,N,8'd0,   Y,Y,Z,            N,N,Z);
    vecs[18] = mk(N,RD,Z,Z,              N,RD,Z,Z,              N, N,N,N,N,8'd0,   N,N,Z,            N,N,Z);

    // Reset state: requests high while in reset must not be acked.
    idle_inputs();
    RstQnnnL = 1'b0;
    c_req = Y; e_req = Y; d2_c_req = Y;
    repeat (2) @(posedge QClk);
    @(negedge QClk);
    check("rst c_ack",       32'(c_ack),       32'h0);
    check("rst e_ack",       32'(e_ack),       32'h0);
    check("rst mem_en",      32'(mem_en),      32'h0);
    check("rst mem_addr",    32'(mem_addr),    32'h0);
    check("rst c_rsp_valid", 32'(c_rsp_valid), 32'h0);
    check("rst e_rsp_valid", 32'(e_rsp_valid), 32'h0);
    check("rst d2_c_ack",    32'(d2_c_ack),    32'h0);
    idle_inputs();
    RstQnnnL = 1'b1;

    // RD_LAT=2: back-to-back reads of words 0 and 1.
    @(posedge QClk); #1;
    d2_c_req = Y; d2_c_op = RD; d2_c_addr = 32'h400;
    @(negedge QClk);
    check("l2 ack0",   32'(d2_c_ack),       32'h1);
    check("l2 addr0",  32'(d2_mem_addr),    32'h0);
    check("l2 rsp0",   32'(d2_c_rsp_valid), 32'h0);
    @(posedge QClk); #1;
    d2_c_addr = 32'h404;
    @(negedge QClk);
    check("l2 ack1",   32'(d2_c_ack),       32'h1);
    check("l2 addr1",  32'(d2_mem_addr),    32'h1);
    check("l2 rsp1",   32'(d2_c_rsp_valid), 32'h0);
    @(posedge QClk); #1;
    d2_c_req = N;
    @(negedge QClk);
    check("l2 ack2",   32'(d2_c_ack),       32'h0);
    check("l2 rsp2 v", 32'(d2_c_rsp_valid), 32'h1);
    check("l2 rsp2 d", d2_c_rsp_rdata,      32'h1000_0000);
    check("l2 rsp2 e", 32'(d2_c_rsp_err),   32'h0);
    @(posedge QClk);
    @(negedge QClk);
    check("l2 rsp3 v", 32'(d2_c_rsp_valid), 32'h1);
    check("l2 rsp3 d", d2_c_rsp_rdata,      32'h1000_0001);
    @(posedge QClk);
    @(negedge QClk);
    check("l2 rsp4 v", 32'(d2_c_rsp_valid), 32'h0);
    check("l2 e_rsp",  32'(d2_e_rsp_valid), 32'h0);

    // Vector table on the RD_LAT=1 instance.
    for (int i = 0; i < 19; i++) begin
      @(posedge QClk); #1;
      c_req = vecs[i].c_req; c_op = vecs[i].c_op; c_addr = vecs[i].c_addr; c_wdata = vecs[i].c_wdata;
      e_req = vecs[i].e_req; e_op = vecs[i].e_op; e_addr = vecs[i].e_addr; e_wdata = vecs[i].e_wdata;
      e_lock = vecs[i].e_lock;
      @(negedge QClk);
      check($sformatf("row%0d c_ack", i),     32'(c_ack),       32'(vecs[i].x_c_ack));
      check($sformatf("row%0d e_ack", i),     32'(e_ack),       32'(vecs[i].x_e_ack));
      check($sformatf("row%0d mem_en", i),    32'(mem_en),      32'(vecs[i].x_en));
      check($sformatf("row%0d mem_wr", i),    32'(mem_wr),      32'(vecs[i].x_wr));
      check($sformatf("row%0d mem_addr", i),  32'(mem_addr),    32'(vecs[i].x_maddr));
      check($sformatf("row%0d c_rsp_v", i),   32'(c_rsp_valid), 32'(vecs[i].x_cv));
      check($sformatf("row%0d c_rsp_err", i), 32'(c_rsp_err),   32'(vecs[i].x_ce));
      check($sformatf("row%0d c_rsp_rd", i),  c_rsp_rdata,      vecs[i].x_crd);
      check($sformatf("row%0d e_rsp_v", i),   32'(e_rsp_valid), 32'(vecs[i].x_ev));
      check($sformatf("row%0d e_rsp_err", i), 32'(e_rsp_err),   32'(vecs[i].x_ee));
      check($sformatf("row%0d e_rsp_rd", i),  e_rsp_rdata,      vecs[i].x_erd);
      if (vecs[i].x_wr) check($sformatf("row%0d mem_wdata", i), mem_wdata, vecs[i].c_wdata);
    end

    // Reset pulsed while a read is in flight.
    @(posedge QClk); #1;
    c_req = Y; c_op = RD; c_addr = 32'h408;
    @(negedge QClk);
    check("mid c_ack", 32'(c_ack), 32'h1);
    @(posedge QClk); #1;
    RstQnnnL = 1'b0;
    c_req = N;
    @(negedge QClk);
    check("mid rst c_rsp_v", 32'(c_rsp_valid), 32'h0);
    check("mid rst mem_en",  32'(mem_en),      32'h0);
    @(posedge QClk); #1;
    c_req = Y; e_req = Y; e_op = RD; e_addr = 32'h404; e_lock = N;
    @(negedge QClk);
    check("mid rst c_ack", 32'(c_ack), 32'h0);
    check("mid rst e_ack", 32'(e_ack), 32'h0);
    @(posedge QClk); #1;
    RstQnnnL = 1'b1;
    @(negedge QClk);
    check("post c_ack",   32'(c_ack),       32'h1);
    check("post e_ack",   32'(e_ack),       32'h0);
    check("post c_rsp_v", 32'(c_rsp_valid), 32'h0);
    check("post e_rsp_v", 32'(e_rsp_valid), 32'h0);
    @(posedge QClk); #1;
    c_req = N;
    @(negedge QClk);
    check("post2 e_ack",   32'(e_ack),       32'h1);
    check("post2 c_rsp_v", 32'(c_rsp_valid), 32'h1);
    check("post2 c_rsp_d", c_rsp_rdata,      32'hDEAD_BEEF);
    check("post2 e_rsp_v", 32'(e_rsp_valid), 32'h0);
    @(posedge QClk); #1;
    idle_inputs();
    @(negedge QClk);
    check("post3 c_rsp_v", 32'(c_rsp_valid), 32'h0);
    check("post3 e_rsp_v", 32'(e_rsp_valid), 32'h1);
    check("post3 e_rsp_d", e_rsp_rdata,      32'h1000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
